// File: rtl/alu_bitcnt_issue.sv
// alu_bitcnt_issue: two-stage issue/retire wrapper around an external
// combinational popcount unit. Requests are turned into a 32-bit mask whose
// popcount is the requested bit count (CPOP, CLZ, CTZ, CZERO). The mask is
// held in S1 and presented on bc_operand. The returned count is captured into
// S2, which drives the result handshake. Both stages follow valid/ready
// backpressure, and the pipeline sustains one result per cycle.
module alu_bitcnt_issue #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      bc_operand,
    input  logic [5:0]       bc_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_count,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_op,
    output logic             out_zero,
    output logic             out_all,
    output logic             busy
);

    typedef enum logic [1:0] {
        OP_CPOP  = 2'b00,
        OP_CLZ   = 2'b01,
        OP_CTZ   = 2'b10,
        OP_CZERO = 2'b11
    } op_e;

    // Stage S1: the mask now presented to the popcount unit.
    logic             r_v1;
    logic [31:0]      r_mask;
    logic [1:0]       r_op1;
    logic [TAG_W-1:0] r_tag1;

    // Stage S2: the captured result on offer to the consumer.
    logic             r_v2;
    logic [5:0]       r_count;
    logic [1:0]       r_op2;
    logic [TAG_W-1:0] r_tag2;
    logic             r_zero;
    logic             r_all;

    logic [31:0]      w_mask;
    logic             w_adv2;
    logic             w_xfer;
    logic             w_accept;

    // Handshake control. S2 can take a new entry when it is empty or is
    // being drained this cycle. S1 can accept when it is empty or is moving on.
    assign w_adv2   = ~r_v2 | out_ready;
    assign w_xfer   = r_v1 & w_adv2;
    assign in_ready = ~r_v1 | w_adv2;
    assign w_accept = in_valid & in_ready;

    // Build the mask whose popcount is the requested count. For CLZ, bit i is
    // set while every bit from 31 down to i is zero. CTZ is the mirror image.
    always_comb begin
        logic run_zero;
        // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
        w_mask   = in_data;
        run_zero = 1'b1;
        case (op_e'(in_op))
            OP_CPOP:  w_mask = in_data;
            OP_CZERO: w_mask = ~in_data;
            OP_CLZ: begin
                for (int i = 31; i >= 0; i--) begin
                    run_zero  = run_zero & ~in_data[i];
                    w_mask[i] = run_zero;
                end
            end
            OP_CTZ: begin
                for (int i = 0; i < 32; i++) begin
                    run_zero  = run_zero & ~in_data[i];
                    w_mask[i] = run_zero;
                end
            end
        endcase
    end

    // S1 register: load on accept, otherwise empty out when the entry moves to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath flops are reset along with the valid bits because their values are visible on outputs straight after reset.
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_mask <= '0;
            r_op1  <= '0;
            r_tag1 <= '0;
        end else if (w_accept) begin
            // NOTE: sequential state uses non-blocking assignment, so every flop samples pre-edge values and the stage order cannot matter.
            r_v1   <= 1'b1;
            r_mask <= w_mask;
            r_op1  <= in_op;
            r_tag1 <= in_tag;
        end else if (w_xfer) begin
            r_v1 <= 1'b0;
        end
    end

    // S2 register: capture the popcount on transfer, otherwise clear when consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_count <= '0;
            r_op2   <= '0;
            r_tag2  <= '0;
            r_zero  <= 1'b0;
            r_all   <= 1'b0;
        end else if (w_xfer) begin
            r_v2    <= 1'b1;
            r_count <= bc_count;
            r_op2   <= r_op1;
            r_tag2  <= r_tag1;
            r_zero  <= (bc_count == 6'd0);
            r_all   <= (bc_count == 6'd32);
        end else if (out_ready) begin
            r_v2 <= 1'b0;
        end
    end

    assign bc_operand = r_mask;
    assign out_valid  = r_v2;
    assign out_count  = r_count;
    assign out_tag    = r_tag2;
    assign out_op     = r_op2;
    assign out_zero   = r_zero;
    assign out_all    = r_all;
    assign busy       = r_v1 | r_v2;

endmodule

// File: tb/tb_alu_bitcnt_issue.sv
// Testbench for alu_bitcnt_issue. The popcount unit is modelled as the true
// popcount of bc_operand. The expected results come from a reference count
// taken directly from the operand and the op.
module tb_alu_bitcnt_issue;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      bc_operand;
    logic [5:0]       bc_count;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_count;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_op;
    logic             out_zero;
    logic             out_all;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [5:0]       cnt;
        logic [TAG_W-1:0] tag;
        logic [1:0]       op;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Ideal combinational popcount unit.
    assign bc_count = 6'($countones(bc_operand));

    alu_bitcnt_issue #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .bc_operand (bc_operand),
        .bc_count   (bc_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_tag    (out_tag),
        .out_op     (out_op),
        .out_zero   (out_zero),
        .out_all    (out_all),
        .busy       (busy)
    );

    // Reference: count the bits the op asks about, straight from the operand.
    function automatic int ref_count(input logic [1:0] op, input logic [31:0] d);
        int n;
        n = 0;
        case (op)
            2'b00: n = $countones(d);
            2'b11: n = 32 - $countones(d);
            2'b01: begin
                int i;
                i = 31;
                while (i >= 0 && d[i] == 1'b0) begin
                    n++;
                    i--;
                end
            end
            default: begin
                int i;
                i = 0;
                while (i < 32 && d[i] == 1'b0) begin
                    n++;
                    i++;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [31:0] gen_data();
        logic [31:0] d;
        case ($urandom_range(0, 5))
            0:       d = 32'h0;
            1:       d = 32'hFFFF_FFFF;
            2:       d = 32'h1 << $urandom_range(0, 31);
            3:       d = ~(32'h1 << $urandom_range(0, 31));
            default: d = $urandom;
        endcase
        return d;
    endfunction

    // Move to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = 32'h0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        sample();
        n_checks++;
        if ({out_valid, out_count, out_tag, out_op, out_zero, out_all, busy} !== '0)
            $display("FAIL reset_outputs: valid=%0b count=%0d tag=%0d op=%0d zero=%0b all=%0b busy=%0b, all must be 0",
                     out_valid, out_count, out_tag, out_op, out_zero, out_all, busy);
        else n_pass++;
        n_checks++;
        if (bc_operand !== 32'h0) $display("FAIL reset_bc_operand: got %h want 0", bc_operand);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;

        // Fill both stages, then pull reset in the middle of a cycle.
        step();
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_data  = 32'h1234_5678;
        in_tag   = 4'd5;
        step();
        in_tag   = 4'd6;
        step();
        in_valid = 1'b0;
        sample();
        n_checks++;
        if ({out_valid, busy} !== 2'b11) $display("FAIL midreset_full: valid,busy=%b want 11", {out_valid, busy});
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy} !== 2'b00) $display("FAIL midreset_clear: valid,busy=%b want 00", {out_valid, busy});
        else n_pass++;
        n_checks++;
        if (bc_operand !== 32'h0) $display("FAIL midreset_bc_operand: got %h want 0", bc_operand);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        sample();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL midreset_release: ready,valid=%b want 10", {in_ready, out_valid});
        else n_pass++;
    endtask

    // Directed ops and boundaries, one at a time, checking the exact latency.
    task automatic test_ops();
        logic [1:0]  t_op  [8] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
        logic [31:0] t_dat [8] = '{32'hF0F0_0001, 32'hF0F0_0001, 32'h0001_0000, 32'h0001_0000,
                                   32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        int          t_exp [8] = '{9, 23, 15, 16, 32, 31, 0, 32};
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            in_valid = 1'b1;
            in_op    = t_op[k];
            in_data  = t_dat[k];
            in_tag   = 4'd3;
            sample();
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL ops_accept[%0d]: in_ready=%b want 1", k, in_ready);
            else n_pass++;
            step();
            in_valid = 1'b0;
            sample();
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL ops_early[%0d]: out_valid=%b want 0 one cycle after accept", k, out_valid);
            else n_pass++;
            step();
            sample();
            n_checks++;
            if ({out_valid, out_count, out_tag, out_op} !== {1'b1, 6'(t_exp[k]), 4'd3, t_op[k]})
                $display("FAIL ops_result[%0d]: valid=%b count=%0d tag=%0d op=%0d want valid=1 count=%0d tag=3 op=%0d",
                         k, out_valid, out_count, out_tag, out_op, t_exp[k], t_op[k]);
            else n_pass++;
            n_checks++;
            if ({out_zero, out_all} !== {t_exp[k] == 0, t_exp[k] == 32})
                $display("FAIL ops_flags[%0d]: zero=%b all=%b for count %0d", k, out_zero, out_all, t_exp[k]);
            else n_pass++;
            step();
            sample();
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL ops_single[%0d]: out_valid=%b want 0 after consume", k, out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] data [5];
        int          idx;
        for (int k = 0; k < 5; k++) data[k] = $urandom;
        idx       = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            in_valid = (idx < 5);
            in_op    = 2'b00;
            in_data  = data[idx % 5];
            in_tag   = TAG_W'(idx);
            sample();
            if (c >= 2) begin
                n_checks++;
                if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 4'd0})
                    $display("FAIL bp_hold[%0d]: ready=%b valid=%b tag=%0d want 0,1,0", c, in_ready, out_valid, out_tag);
                else n_pass++;
                n_checks++;
                if (out_count !== 6'($countones(data[0])))
                    $display("FAIL bp_count[%0d]: got %0d want %0d", c, out_count, $countones(data[0]));
                else n_pass++;
                n_checks++;
                if (bc_operand !== data[1]) $display("FAIL bp_operand[%0d]: got %h want %h", c, bc_operand, data[1]);
                else n_pass++;
            end
            if (in_valid && in_ready) idx++;
        end
        n_checks++;
        if (idx !== 2) $display("FAIL bp_accepts: %0d accepted while stalled, want 2", idx);
        else n_pass++;

        for (int k = 0; k < 5; k++) begin
            step();
            out_ready = 1'b1;
            in_valid  = (idx < 5);
            in_data   = data[idx % 5];
            in_tag    = TAG_W'(idx);
            sample();
            n_checks++;
            if ({out_valid, out_tag, out_count} !== {1'b1, TAG_W'(k), 6'($countones(data[k]))})
                $display("FAIL bp_drain[%0d]: valid=%b tag=%0d count=%0d want 1,%0d,%0d",
                         k, out_valid, out_tag, out_count, k, $countones(data[k]));
            else n_pass++;
            if (in_valid && in_ready) idx++;
        end
        step();
        in_valid = 1'b0;
        sample();
        n_checks++;
        if ({idx == 5, out_valid, busy} !== 3'b100)
            $display("FAIL bp_end: accepted=%0d valid=%b busy=%b want 5,0,0", idx, out_valid, busy);
        else n_pass++;
    endtask

    task automatic test_random();
        int          issued, done;
        logic        hold;
        logic [5:0]  s_count;
        logic [3:0]  s_tag;
        logic [1:0]  s_op;
        logic        s_zero, s_all;
        exp_t        e;
        issued = 0;
        done   = 0;
        hold   = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 60000 && done < 10000; cyc++) begin
            step();
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (issued < 10000) && ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_data   = gen_data();
            in_tag    = TAG_W'($urandom);
            sample();
            if (hold) begin
                n_checks++;
                if ({out_valid, out_count, out_tag, out_op, out_zero, out_all} !== {1'b1, s_count, s_tag, s_op, s_zero, s_all})
                    $display("FAIL rnd_stable@%0d: valid=%b count=%0d tag=%0d changed while stalled (was %0d/%0d)",
                             cyc, out_valid, out_count, out_tag, s_count, s_tag);
                else n_pass++;
            end
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rnd_spurious@%0d: out_valid with tag %0d but nothing outstanding", cyc, out_tag);
                end else begin
                    e = exp_q[0];
                    if ({out_count, out_tag, out_op, out_zero, out_all} !== {e.cnt, e.tag, e.op, e.cnt == 6'd0, e.cnt == 6'd32})
                        $display("FAIL rnd_result@%0d: count=%0d tag=%0d op=%0d z=%b a=%b want count=%0d tag=%0d op=%0d",
                                 cyc, out_count, out_tag, out_op, out_zero, out_all, e.cnt, e.tag, e.op);
                    else n_pass++;
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        done++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{cnt: 6'(ref_count(in_op, in_data)), tag: in_tag, op: in_op});
                issued++;
            end
            hold    = out_valid && !out_ready;
            s_count = out_count;
            s_tag   = out_tag;
            s_op    = out_op;
            s_zero  = out_zero;
            s_all   = out_all;
        end
        n_checks++;
        if (done != 10000 || exp_q.size() != 0)
            $display("FAIL rnd_complete: %0d results retired, %0d outstanding, want 10000 and 0", done, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   results;
        exp_t e;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && busy; c++) step();
        sample();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b_drain: busy=%b want 0 before streaming", busy);
        else n_pass++;
        exp_q.delete();
        results = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            step();
            in_valid = 1'b1;
            in_op    = 2'($urandom_range(0, 3));
            in_data  = gen_data();
            in_tag   = TAG_W'(cyc);
            sample();
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready@%0d: in_ready=%b want 1", cyc, in_ready);
            else n_pass++;
            if (cyc >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1) $display("FAIL b2b_gap@%0d: out_valid=%b want 1", cyc, out_valid);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_spurious@%0d: result tag %0d with nothing outstanding", cyc, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_count, out_tag, out_op} !== {e.cnt, e.tag, e.op})
                        $display("FAIL b2b_result@%0d: count=%0d tag=%0d op=%0d want %0d,%0d,%0d",
                                 cyc, out_count, out_tag, out_op, e.cnt, e.tag, e.op);
                    else n_pass++;
                end
                results++;
            end
            if (in_valid && in_ready)
                exp_q.push_back('{cnt: 6'(ref_count(in_op, in_data)), tag: in_tag, op: in_op});
        end
        n_checks++;
        if (results != 98) $display("FAIL b2b_count: %0d results in 100 cycles, want 98", results);
        else n_pass++;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_bitcnt_issue.md
Name: alu_bitcnt_issue

Overview:
Pipelined issue/retire stage wrapped around the combinational population-count unit. It accepts bit-count requests over a valid/ready handshake and converts each operand into a 32-bit mask according to the requested op: CPOP, CLZ, CTZ or CZERO. It registers the mask, drives it to the popcount unit, captures the 6-bit count and returns it through an output handshake. Two pipeline stages with full backpressure; one result per cycle sustained.

Parameters:
TAG_W, 4, width of the request tag carried alongside each operation.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  stage can accept a request this cycle
in_op  input  2  00 CPOP, 01 CLZ, 10 CTZ, 11 CZERO (count of zero bits)
in_data  input  32  operand
in_tag  input  TAG_W  request tag
bc_operand  output  32  registered mask driven to popcount unit
bc_count  input  6  popcount of bc_operand, combinational return
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_count  output  6  result, 0..32
out_tag  output  TAG_W  tag of the result
out_op  output  2  op of the result
out_zero  output  1  out_count == 0
out_all  output  1  out_count == 32
busy  output  1  either stage holds a valid entry

Behaviour:
- Reset is asynchronous and active-low. All state is cleared. Outputs after reset: out_valid=0, out_count=0, out_tag=0, out_op=0, out_zero=0, out_all=0, bc_operand=0, busy=0. in_ready=1 once reset is released.
- Mask generation (combinational, before S1):
  - CPOP: m = in_data.
  - CZERO: m = ~in_data.
  - CLZ: m[i] = ~|in_data[31:i].
  - CTZ: m[i] = ~|in_data[i:0].
  - Consequence: for in_data=0, CLZ and CTZ both give 32.
- Stage S1 register holds {v1, mask, op, tag}. bc_operand = S1 mask, held stable while S1 is stalled.
- Stage S2 register holds {v2, count, op, tag}. out_* are driven from S2. out_zero and out_all are registered alongside count.
- Advance rules:
  - adv2 = ~v2 | out_ready.
  - S1→S2 transfer happens when v1 & adv2. S2 captures bc_count.
  - in_ready = ~v1 | adv2. Purely combinational from registered state and out_ready; no dependence on in_valid.
  - Accept happens when in_valid & in_ready. S1 loads the new mask; v1 <= 1.
  - If S1 moves to S2 with no new accept, v1 <= 0.
  - If S2 is consumed (out_valid & out_ready) with no transfer into it, v2 <= 0.
- Latency: a request accepted in cycle N appears with out_valid=1 in cycle N+2 if there is no backpressure.
- Throughput: 1 request/cycle while out_ready=1.
- Full condition: v1=v2=1 and out_ready=0 → in_ready=0. Both entries hold their contents unchanged, and bc_operand stays stable.
- Simultaneous events: consume S2, move S1→S2 and accept a new request can all happen in the same cycle. Nothing is lost or duplicated.
- out_valid, once asserted, stays high with stable out_* until out_ready is sampled high.
- Ordering is strictly in-order; tags are never reordered.
- busy = v1 | v2.
- Reset asserted mid-operation: in-flight entries are discarded with no output. This is legal even while out_valid=1.
- in_op, in_data and in_tag are ignored when in_valid=0.
- bc_count is assumed to be the true popcount of bc_operand in the same cycle.

Test Plan:
- Reset: assert rst_n=0 mid-stream with v1=v2=1 → out_valid=0, busy=0, bc_operand=0 immediately; in_ready=1 after release.
- Op coverage, tag 3, out_ready=1: CPOP 0xF0F0_0001 → 9; CZERO 0xF0F0_0001 → 23; CLZ 0x0001_0000 → 15; CTZ 0x0001_0000 → 16. Each result appears exactly 2 cycles after its accept.
- Boundaries:
  - CLZ 0x0000_0000 → 32 with out_all=1.
  - CTZ 0x8000_0000 → 31.
  - CLZ 0x8000_0000 → 0 with out_zero=1.
  - CPOP 0xFFFF_FFFF → 32.
- Backpressure: stream 5 requests with tags 0..4 and hold out_ready=0.
  - in_ready drops after 2 accepts; out_valid=1 with tag 0 held stable; bc_operand held stable.
  - Release out_ready → results for tags 0..4 arrive in order with no gaps, loss or duplication.
- Random throttling: random in_valid/out_ready over 10k ops compared against a scoreboard model → all counts and tags match, and no out_* change while out_valid & ~out_ready.
- Full throughput: in_valid=1 and out_ready=1 for 100 cycles → 98 results by cycle 100, one per cycle, in_ready constantly 1.
